// File: rtl/uart_pkg.sv
// Shared UART receive constants: oversampling rate, ASCII codes and the rx FSM state encoding.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int OS_W       = $clog2(OVERSAMPLE);

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 16x-oversampled UART byte receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
// Output pulses are registered: data_strobe/frame_err/parity_err are high for exactly one clk.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int SAMPLE_DIV = 78
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] data,
  output logic       data_strobe,
  output logic       frame_err,
  output logic       parity_err,
  output rx_state_t  state_dbg
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic             rx_meta, rxs;
  logic [CNT_W-1:0] cnt;
  logic [OS_W-1:0]  os;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  rx_state_t        state, state_nxt;
  logic             tick, mid;
  logic             load_byte, frame_fire, par_fire, par_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= serial_rx;
      rxs     <= rx_meta;
    end
  end

  assign tick = (cnt == CNT_W'(SAMPLE_DIV - 1));
  assign mid  = tick && (os == OS_W'(MID_SAMPLE));

  // Counters rest at zero while idle so the first tick is phase-locked to the start edge;
  // os then wraps every 16 ticks, keeping every later os=7 sample at mid-bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      os  <= '0;
    end else if (state == RX_IDLE || state == RX_WAIT_HIGH) begin
      cnt <= '0;
      os  <= '0;
    end else if (tick) begin
      cnt <= '0;
      os  <= os + OS_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_idx <= '0;
      shift   <= '0;
    end else if (state == RX_START) begin
      bit_idx <= '0;
    end else if (state == RX_DATA && mid) begin
      shift   <= {rxs, shift[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_byte  = 1'b0;
    frame_fire = 1'b0;
    par_fire   = 1'b0;
    case (state)
      RX_IDLE:  if (!rxs) state_nxt = RX_START;
      RX_START: if (mid) state_nxt = rxs ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (mid && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = RX_PARITY;
`else
          state_nxt = RX_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (mid) begin
          par_fire  = (rxs != ^shift);
          state_nxt = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (mid) begin
          if (rxs) begin
            load_byte = !par_bad;
            state_nxt = RX_IDLE;
          end else begin
            frame_fire = 1'b1;
            state_nxt  = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: if (rxs) state_nxt = RX_IDLE;
      default: state_nxt = RX_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_fire;
      if (state == RX_START) par_bad <= 1'b0;
      else if (par_fire)     par_bad <= 1'b1;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data        <= '0;
      data_strobe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_strobe <= load_byte;
      frame_err   <= frame_fire;
      if (load_byte) data <= shift;
    end
  end

  assign state_dbg = state;

endmodule

// File: rtl/uart_rx_bcd_uint32.sv
// UART receive path that assembles CR/LF-terminated ASCII decimal lines into packed BCD.
// Even-parity reception is built in when UART_RX_PARITY_EN is defined.
module uart_rx_bcd_uint32
  import uart_pkg::*;
#(
  parameter int SAMPLE_DIV = 78,
  parameter int MAX_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    serial_rx,
  output logic [7:0]              data,
  output logic                    data_strobe,
  output logic                    frame_err,
  output logic [4*MAX_DIGITS-1:0] value,
  output logic                    value_strobe,
  output logic                    line_err,
  output logic                    parity_err,
  output rx_state_t               rx_state
);

  localparam int VW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic [VW-1:0] acc;
  logic [CW-1:0] count;
  logic          is_digit, is_term;

  uart_rx_byte #(.SAMPLE_DIV(SAMPLE_DIV)) u_rx (
    .clk         (clk),
    .reset       (reset),
    .serial_rx   (serial_rx),
    .data        (data),
    .data_strobe (data_strobe),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .state_dbg   (rx_state)
  );

  assign is_digit = (data >= ASCII_0) && (data <= ASCII_9);
  assign is_term  = (data == ASCII_CR) || (data == ASCII_LF);

  // Digits beyond MAX_DIGITS simply push the oldest digit out of the top of acc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      count        <= '0;
      value        <= '0;
      value_strobe <= 1'b0;
      line_err     <= 1'b0;
    end else begin
      value_strobe <= 1'b0;
      line_err     <= 1'b0;
      if (data_strobe) begin
        if (is_digit) begin
          acc <= {acc[VW-5:0], data[3:0]};
          if (count != CW'(MAX_DIGITS)) count <= count + CW'(1);
        end else if (is_term) begin
          if (count != '0) begin
            value        <= acc;
            value_strobe <= 1'b1;
            acc          <= '0;
            count        <= '0;
          end
        end else begin
          acc      <= '0;
          count    <= '0;
          line_err <= 1'b1;
        end
      end
    end
  end

endmodule
